mem_stage: RTL and testbench
============================

# mem_stage

Memory stage sitting directly downstream of the execute stage. It registers execute results (scalar, vector, ALU flags) and performs scalar or vector loads and stores against the data memory through a request/grant/rvalid port. It stalls the upstream pipeline while an access is outstanding and presents a registered writeback bundle to the register-file stage.

## Interface
Parameters:
- REGI_BITS, 4, scalar/vector destination register index width
- MEMO_LINES, 64, data memory lines; address width AW = $clog2(MEMO_LINES)
- VECT_SIZE, 8, lanes per vector / per memory line
- ELEM_SIZE, 8, bits per element; line width LW = ELEM_SIZE*VECT_SIZE

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- ex_valid_i  in  1  execute bundle valid
- stall_o  out  1  upstream must hold its bundle
- ialu_res_i  in  ELEM_SIZE  scalar result; low AW bits are the memory address for memory ops
- valu_res_i  in  LW  vector result
- alu_flags_i  in  2  flags from execute
- flag_update_i  in  1  latch alu_flags_i into flags_o
- mem_read_i / mem_write_i  in  1 each  load / store (never both)
- mem_vec_i  in  1  1 = full-line access, 0 = single element
- mem_elem_i  in  $clog2(VECT_SIZE)  element index for scalar access
- st_int_i  in  ELEM_SIZE  scalar store data
- st_vec_i  in  LW  vector store data
- wb_en_i  in  1  instruction writes a register
- wb_vec_i  in  1  destination is vector file
- rd_i  in  REGI_BITS  destination index
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  write request
- dmem_addr_o  out  AW  line address
- dmem_be_o  out  VECT_SIZE  per-lane write enable
- dmem_wdata_o  out  LW  write data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  LW  read data
- wb_valid_o  out  1  writeback bundle valid (single-cycle pulse per instruction)
- wb_vec_o  out  1  registered wb_vec_i
- wb_rd_o  out  REGI_BITS  registered rd_i
- wb_int_o  out  ELEM_SIZE  scalar writeback data
- wb_vec_data_o  out  LW  vector writeback data
- flags_o  out  2  architectural flags, feed the execute condition unit

## Operation
- Accept = ex_valid_i && !stall_o. Lane k occupies bits [k*ELEM_SIZE +: ELEM_SIZE].
- FSM states IDLE, REQ, WAIT. stall_o = (state != IDLE), combinational.
- IDLE, accept, no memory op: register wb fields; wb_valid_o = wb_en_i next cycle; wb_int_o = ialu_res_i, wb_vec_data_o = valu_res_i. Stay IDLE.
- IDLE, accept, memory op: latch address (ialu_res_i[AW-1:0], i.e. modulo MEMO_LINES), element, store data, wb fields; -> REQ.
- REQ: dmem_req_o = 1, outputs stable until grant. Store: dmem_we_o = 1; vector be = all ones, wdata = st_vec; scalar be = one-hot at element, wdata = st_int replicated to every lane. On gnt: store -> IDLE, no wb_valid_o; load -> WAIT.
- WAIT: dmem_req_o = 0. On dmem_rvalid_i: -> IDLE; next cycle wb_valid_o = wb_en, wb_vec_data_o = rdata, wb_int_o = rdata lane element.
- dmem_rvalid_i outside WAIT is ignored.
- flags_o loads alu_flags_i at accept when flag_update_i, independent of op type; unchanged otherwise.
- Reset (any state, mid-access included): state IDLE, all outputs 0, flags_o = 2'b00; an in-flight response arriving after reset is ignored.

## Timing
- Non-memory op: accept at edge N -> wb_valid_o high cycle N..N+1 (one cycle), latency 1.
- Store with gnt on first REQ cycle: accept edge N, req high cycle after N, gnt sampled edge N+1, stall_o low after N+1; occupancy 1 extra cycle.
- Load with gnt at edge G and rvalid at edge R > G: wb_valid_o high for the cycle after R; stall_o falls after R, allowing accept on the same cycle wb_valid_o is high.
- Grant wait and response wait unbounded; no timeout.
- wb_valid_o never high two consecutive cycles for the same instruction; back-to-back ALU ops give one pulse per accept.

## Test plan
- Reset mid-WAIT (rst_i low 1 cycle) -> stall_o=0, dmem_req_o=0, flags_o=00, late rvalid produces no wb_valid_o.
- Three back-to-back ALU ops, ex_valid_i continuously high, ialu_res_i 0x11/0x22/0x33, rd 1/2/3 -> three consecutive wb_valid_o pulses, wb_int_o 0x11/0x22/0x33, stall_o never high.
- Scalar store addr 0x45 (wraps to line 5), elem 3, st_int 0xA5, gnt delayed 3 cycles -> dmem_addr_o=5, be=0x08, every lane 0xA5, req held 4 cycles, no wb_valid_o.
- Vector load line 10, gnt immediate, rvalid 2 cycles later with rdata lane k = k+1 -> wb_vec_data_o lane k = k+1, wb_vec_o=1, stall_o high 3 cycles.
- Scalar load elem 6 of same data -> wb_int_o = 0x07; spurious rvalid during REQ ignored.
- flag_update_i=1, alu_flags 10 on a load accept, then flag_update_i=0 with flags 01 -> flags_o=10 persists.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: registers execute results, runs scalar/vector loads and stores
// over a req/gnt/rvalid data-memory port, stalls upstream while busy, and
// presents a registered writeback bundle.
module mem_stage #(
  parameter int REGI_BITS  = 4,
  parameter int MEMO_LINES = 64,
  parameter int VECT_SIZE  = 8,
  parameter int ELEM_SIZE  = 8,
  localparam int AW = $clog2(MEMO_LINES),
  localparam int LW = ELEM_SIZE * VECT_SIZE,
  localparam int EW = $clog2(VECT_SIZE)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_valid_i,
  output logic                 stall_o,
  input  logic [ELEM_SIZE-1:0] ialu_res_i,
  input  logic [LW-1:0]        valu_res_i,
  input  logic [1:0]           alu_flags_i,
  input  logic                 flag_update_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic                 mem_vec_i,
  input  logic [EW-1:0]        mem_elem_i,
  input  logic [ELEM_SIZE-1:0] st_int_i,
  input  logic [LW-1:0]        st_vec_i,
  input  logic                 wb_en_i,
  input  logic                 wb_vec_i,
  input  logic [REGI_BITS-1:0] rd_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [AW-1:0]        dmem_addr_o,
  output logic [VECT_SIZE-1:0] dmem_be_o,
  output logic [LW-1:0]        dmem_wdata_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [LW-1:0]        dmem_rdata_i,
  output logic                 wb_valid_o,
  output logic                 wb_vec_o,
  output logic [REGI_BITS-1:0] wb_rd_o,
  output logic [ELEM_SIZE-1:0] wb_int_o,
  output logic [LW-1:0]        wb_vec_data_o,
  output logic [1:0]           flags_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [EW-1:0]          elem_q, elem_d;
  logic [ELEM_SIZE-1:0]   st_int_q, st_int_d;
  logic [LW-1:0]          st_vec_q, st_vec_d;
  logic                   is_wr_q, is_wr_d;
  logic                   is_vec_q, is_vec_d;
  logic                   pend_wb_q, pend_wb_d;
  logic                   wb_valid_q, wb_valid_d;
  logic                   wb_vec_q, wb_vec_d;
  logic [REGI_BITS-1:0]   wb_rd_q, wb_rd_d;
  logic [ELEM_SIZE-1:0]   wb_int_q, wb_int_d;
  logic [LW-1:0]          wb_vec_data_q, wb_vec_data_d;
  logic [1:0]             flags_q, flags_d;

  logic                   accept;
  logic                   mem_op;
  logic                   in_req;
  logic                   wr_act;
  logic [VECT_SIZE-1:0]   elem_onehot;
  logic [ELEM_SIZE-1:0]   rd_lane;

  assign accept      = ex_valid_i && (state_q == IDLE);
  assign mem_op      = mem_read_i || mem_write_i;
  assign in_req      = (state_q == REQ);
  assign wr_act      = in_req && is_wr_q;
  assign elem_onehot = {{(VECT_SIZE-1){1'b0}}, 1'b1} << elem_q;
  assign rd_lane     = dmem_rdata_i[elem_q*ELEM_SIZE +: ELEM_SIZE];

  // Memory port is driven only from registered request state so it holds steady until grant.
  assign stall_o      = (state_q != IDLE);
  assign dmem_req_o   = in_req;
  assign dmem_we_o    = wr_act;
  assign dmem_addr_o  = in_req ? addr_q : '0;
  assign dmem_be_o    = wr_act ? (is_vec_q ? {VECT_SIZE{1'b1}} : elem_onehot) : '0;
  assign dmem_wdata_o = wr_act ? (is_vec_q ? st_vec_q : {VECT_SIZE{st_int_q}}) : '0;

  assign wb_valid_o    = wb_valid_q;
  assign wb_vec_o      = wb_vec_q;
  assign wb_rd_o       = wb_rd_q;
  assign wb_int_o      = wb_int_q;
  assign wb_vec_data_o = wb_vec_data_q;
  assign flags_o       = flags_q;

  // Next-state: accept in IDLE, hold request until grant, capture load data on rvalid.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    elem_d        = elem_q;
    st_int_d      = st_int_q;
    st_vec_d      = st_vec_q;
    is_wr_d       = is_wr_q;
    is_vec_d      = is_vec_q;
    pend_wb_d     = pend_wb_q;
    wb_valid_d    = 1'b0;
    wb_vec_d      = wb_vec_q;
    wb_rd_d       = wb_rd_q;
    wb_int_d      = wb_int_q;
    wb_vec_data_d = wb_vec_data_q;
    flags_d       = flags_q;

    if (accept && flag_update_i) flags_d = alu_flags_i;

    case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          wb_vec_d = wb_vec_i;
          wb_rd_d  = rd_i;
          if (mem_op) begin
            addr_d    = ialu_res_i[AW-1:0];
            elem_d    = mem_elem_i;
            st_int_d  = st_int_i;
            st_vec_d  = st_vec_i;
            is_wr_d   = mem_write_i;
            is_vec_d  = mem_vec_i;
            pend_wb_d = wb_en_i;
            state_d   = REQ;
          end else begin
            wb_valid_d    = wb_en_i;
            wb_int_d      = ialu_res_i;
            wb_vec_data_d = valu_res_i;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) state_d = is_wr_q ? IDLE : WAIT;
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          state_d       = IDLE;
          wb_valid_d    = pend_wb_q;
          wb_int_d      = rd_lane;
          wb_vec_data_d = dmem_rdata_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight access.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      elem_q        <= '0;
      st_int_q      <= '0;
      st_vec_q      <= '0;
      is_wr_q       <= 1'b0;
      is_vec_q      <= 1'b0;
      pend_wb_q     <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_vec_q      <= 1'b0;
      wb_rd_q       <= '0;
      wb_int_q      <= '0;
      wb_vec_data_q <= '0;
      flags_q       <= 2'b00;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      elem_q        <= elem_d;
      st_int_q      <= st_int_d;
      st_vec_q      <= st_vec_d;
      is_wr_q       <= is_wr_d;
      is_vec_q      <= is_vec_d;
      pend_wb_q     <= pend_wb_d;
      wb_valid_q    <= wb_valid_d;
      wb_vec_q      <= wb_vec_d;
      wb_rd_q       <= wb_rd_d;
      wb_int_q      <= wb_int_d;
      wb_vec_data_q <= wb_vec_data_d;
      flags_q       <= flags_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level model (memory image, expected request
// and writeback queues), a randomized memory responder, directed cases with
// literal expectations, and a randomized instruction stream.
module tb_mem_stage;
  localparam int RB = 4, LINES = 64, VS = 8, ES = 8, LW = 64, AW = 6;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ex_valid, stall_o;
  logic [ES-1:0] ialu, st_int;
  logic [LW-1:0] valu, st_vec;
  logic [1:0] alu_flags, flags_o;
  logic flag_upd, mrd, mwr, mvec, wb_en, wb_vec;
  logic [2:0] melem;
  logic [RB-1:0] rd;
  logic dmem_req_o, dmem_we_o;
  logic [AW-1:0] dmem_addr_o;
  logic [VS-1:0] dmem_be_o;
  logic [LW-1:0] dmem_wdata_o, dmem_rdata;
  logic dmem_gnt, dmem_rvalid;
  logic wb_valid_o, wb_vec_o;
  logic [RB-1:0] wb_rd_o;
  logic [ES-1:0] wb_int_o;
  logic [LW-1:0] wb_vec_data_o;

  always #5 clk = ~clk;

  mem_stage #(.REGI_BITS(RB), .MEMO_LINES(LINES), .VECT_SIZE(VS), .ELEM_SIZE(ES)) dut (
    .clk_i(clk), .rst_i(rst_n), .ex_valid_i(ex_valid), .stall_o(stall_o),
    .ialu_res_i(ialu), .valu_res_i(valu), .alu_flags_i(alu_flags), .flag_update_i(flag_upd),
    .mem_read_i(mrd), .mem_write_i(mwr), .mem_vec_i(mvec), .mem_elem_i(melem),
    .st_int_i(st_int), .st_vec_i(st_vec), .wb_en_i(wb_en), .wb_vec_i(wb_vec), .rd_i(rd),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt),
    .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
    .wb_valid_o(wb_valid_o), .wb_vec_o(wb_vec_o), .wb_rd_o(wb_rd_o), .wb_int_o(wb_int_o),
    .wb_vec_data_o(wb_vec_data_o), .flags_o(flags_o)
  );

  typedef struct packed {
    logic [ES-1:0] ialu; logic [LW-1:0] valu; logic [1:0] fl; logic fupd;
    logic rd; logic wr; logic vec; logic [2:0] elem; logic [ES-1:0] sti;
    logic [LW-1:0] stv; logic wben; logic wbvec; logic [RB-1:0] rdi;
  } op_t;
  typedef struct packed { logic vec; logic [RB-1:0] rd; logic [ES-1:0] i; logic [LW-1:0] v; } wb_t;
  typedef struct packed { logic we; logic [AW-1:0] a; logic [VS-1:0] be; logic [LW-1:0] wd; } rq_t;

  wb_t wbq[$];
  rq_t rqq[$];
  logic [LW-1:0] mm [LINES];   // model's view of memory
  logic [LW-1:0] ram [LINES];  // responder's memory, written only by DUT stores
  logic [1:0] mflags = 2'b00;
  int tests = 0, fails = 0, wb_seen = 0;
  int gnt_dly = -1, rv_dly = -1, spur = 0;
  rq_t last_rq;
  int last_held = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: what an accepted instruction must eventually produce.
  task automatic model_accept(input op_t o);
    rq_t r;
    wb_t w;
    logic [AW-1:0] a;
    a = o.ialu[AW-1:0];
    if (o.fupd) mflags = o.fl;
    if (o.rd || o.wr) begin
      r.we = o.wr;
      r.a  = a;
      r.be = o.vec ? 8'hFF : (8'h01 << o.elem);
      r.wd = o.vec ? o.stv : {VS{o.sti}};
      rqq.push_back(r);
      if (o.wr) begin
        if (o.vec) mm[a] = o.stv;
        else mm[a][o.elem*ES +: ES] = o.sti;
      end else if (o.wben) begin
        w.vec = o.wbvec; w.rd = o.rdi; w.i = mm[a][o.elem*ES +: ES]; w.v = mm[a];
        wbq.push_back(w);
      end
    end else if (o.wben) begin
      w.vec = o.wbvec; w.rd = o.rdi; w.i = o.ialu; w.v = o.valu;
      wbq.push_back(w);
    end
  endtask

  function automatic op_t blank();
    op_t o;
    o = '0;
    return o;
  endfunction

  // Drive one instruction, wait (bounded) for it to be accepted, update the model.
  task automatic issue(input op_t o);
    int n;
    n = 0;
    ex_valid = 1'b1; ialu = o.ialu; valu = o.valu; alu_flags = o.fl; flag_upd = o.fupd;
    mrd = o.rd; mwr = o.wr; mvec = o.vec; melem = o.elem; st_int = o.sti; st_vec = o.stv;
    wb_en = o.wben; wb_vec = o.wbvec; rd = o.rdi;
    while (stall_o && n < 200) begin @(posedge clk); #1; n++; end
    if (stall_o) chk("accept timeout", 1, 0);
    @(posedge clk);
    model_accept(o);
    #1 ex_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (stall_o && cnt < 200) begin cnt++; @(posedge clk); #1; end
    if (stall_o) chk("idle timeout", 1, 0);
  endtask

  // Memory responder: grants after a delay, optionally pulses stray rvalid while
  // the request is pending, answers loads from ram and applies stores to it.
  initial begin
    int d, held, r;
    rq_t got, ex;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && dmem_req_o) begin
        d = (gnt_dly >= 0) ? gnt_dly : $urandom_range(0, 3);
        held = 0;
        repeat (d) begin
          if (dmem_req_o) held++;
          if (spur == 1 || (spur == 2 && $urandom_range(0, 1) == 1)) begin
            dmem_rvalid = 1'b1; dmem_rdata = {$urandom, $urandom};
          end
          @(negedge clk);
          dmem_rvalid = 1'b0;
        end
        if (dmem_req_o) held++;
        got.we = dmem_we_o; got.a = dmem_addr_o; got.be = dmem_be_o; got.wd = dmem_wdata_o;
        last_rq = got; last_held = held;
        dmem_gnt = 1'b1;
        if (rqq.size() == 0) chk("unexpected dmem request", 1, 0);
        else begin
          ex = rqq.pop_front();
          chk("req we", got.we, ex.we);
          chk("req addr", got.a, ex.a);
          if (ex.we) begin
            chk("req be", got.be, ex.be);
            chk("req wdata", got.wd, ex.wd);
          end
        end
        @(negedge clk);
        dmem_gnt = 1'b0;
        if (got.we) begin
          for (int k = 0; k < VS; k++)
            if (got.be[k]) ram[got.a][k*ES +: ES] = got.wd[k*ES +: ES];
        end else begin
          r = (rv_dly >= 0) ? rv_dly : $urandom_range(0, 3);
          repeat (r) @(negedge clk);
          dmem_rvalid = 1'b1; dmem_rdata = ram[got.a];
          @(negedge clk);
          dmem_rvalid = 1'b0;
        end
      end
    end
  end

  // Every-cycle compare: flags and each writeback pulse against the model queue.
  initial begin
    wb_t w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("flags_o", flags_o, mflags);
        if (wb_valid_o) begin
          wb_seen++;
          if (wbq.size() == 0) chk("unexpected wb_valid_o", 1, 0);
          else begin
            w = wbq.pop_front();
            chk("wb_vec_o", wb_vec_o, w.vec);
            chk("wb_rd_o", wb_rd_o, w.rd);
            chk("wb_int_o", wb_int_o, w.i);
            chk("wb_vec_data_o", wb_vec_data_o, w.v);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    op_t o;
    int cnt, s, kind;
    logic [LW-1:0] pat;
    for (int i = 0; i < LINES; i++) begin
      pat = {$urandom, $urandom};
      mm[i] = pat; ram[i] = pat;
    end
    pat = 64'h0807_0605_0403_0201;
    mm[10] = pat; ram[10] = pat;
    o = blank();
    ex_valid = 0; ialu = 0; valu = 0; alu_flags = 0; flag_upd = 0; mrd = 0; mwr = 0;
    mvec = 0; melem = 0; st_int = 0; st_vec = 0; wb_en = 0; wb_vec = 0; rd = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst stall_o", stall_o, 0);
    chk("rst dmem_req_o", dmem_req_o, 0);
    chk("rst wb_valid_o", wb_valid_o, 0);
    chk("rst flags_o", flags_o, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Three back-to-back ALU ops
    for (int k = 1; k <= 3; k++) begin
      o = blank(); o.ialu = 8'(k * 8'h11); o.valu = {8{8'(k)}}; o.wben = 1; o.rdi = 4'(k);
      issue(o);
      chk("b2b wb_valid_o", wb_valid_o, 1);
      chk("b2b wb_int_o", wb_int_o, 64'(k * 8'h11));
      chk("b2b stall_o", stall_o, 0);
    end
    @(posedge clk); #1;
    chk("b2b single pulse", wb_valid_o, 0);

    // Scalar store, address wraps, grant delayed 3 cycles
    gnt_dly = 3; s = wb_seen;
    o = blank(); o.wr = 1; o.ialu = 8'h45; o.elem = 3; o.sti = 8'hA5; o.wben = 1; o.rdi = 5;
    issue(o);
    wait_idle(cnt);
    chk("st addr", last_rq.a, 5);
    chk("st be", last_rq.be, 8'h08);
    chk("st wdata", last_rq.wd, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("st req cycles", last_held, 4);
    repeat (2) @(posedge clk); #1;
    chk("st no wb", wb_seen, s);

    // Vector load line 10, grant immediate, rvalid 2 cycles after grant
    gnt_dly = 0; rv_dly = 1;
    o = blank(); o.rd = 1; o.vec = 1; o.ialu = 8'h8A; o.wben = 1; o.wbvec = 1; o.rdi = 7;
    issue(o);
    wait_idle(cnt);
    chk("vld stall cycles", cnt, 3);
    chk("vld wb_valid_o", wb_valid_o, 1);
    chk("vld wb_vec_o", wb_vec_o, 1);
    chk("vld data", wb_vec_data_o, 64'h0807_0605_0403_0201);

    // Scalar load elem 6, stray rvalid during the request phase
    gnt_dly = 2; rv_dly = 0; spur = 1;
    o = blank(); o.rd = 1; o.elem = 6; o.ialu = 8'h0A; o.wben = 1; o.rdi = 3;
    issue(o);
    wait_idle(cnt);
    spur = 0;
    chk("sld wb_valid_o", wb_valid_o, 1);
    chk("sld wb_int_o", wb_int_o, 8'h07);

    // Flags latched on a load accept persist through a non-updating op
    gnt_dly = 0;
    o = blank(); o.rd = 1; o.ialu = 8'h0A; o.fupd = 1; o.fl = 2'b10;
    issue(o);
    o = blank(); o.fupd = 0; o.fl = 2'b01; o.wben = 1; o.ialu = 8'h5C; o.rdi = 2;
    issue(o);
    chk("flags persist", flags_o, 2'b10);
    @(posedge clk); #1;

    // Reset while waiting for read data; the late response must be ignored
    gnt_dly = 0; rv_dly = 5;
    o = blank(); o.rd = 1; o.ialu = 8'h0A; o.fupd = 1; o.fl = 2'b11; o.wben = 1; o.rdi = 9;
    issue(o);
    @(posedge clk); #1;
    chk("wait stall_o", stall_o, 1);
    chk("wait dmem_req_o", dmem_req_o, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    wbq.delete(); rqq.delete(); mflags = 2'b00;
    #1;
    chk("midrst stall_o", stall_o, 0);
    chk("midrst dmem_req_o", dmem_req_o, 0);
    chk("midrst flags_o", flags_o, 0);
    chk("midrst wb_valid_o", wb_valid_o, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    s = wb_seen;
    repeat (10) @(posedge clk); #1;
    chk("late rvalid ignored", wb_seen, s);

    // Randomized instruction stream
    gnt_dly = -1; rv_dly = -1; spur = 2;
    for (int n = 0; n < 400; n++) begin
      o = blank();
      kind = $urandom_range(0, 3);
      o.valu = {$urandom, $urandom}; o.fl = 2'($urandom); o.fupd = 1'($urandom);
      o.elem = 3'($urandom); o.sti = 8'($urandom); o.stv = {$urandom, $urandom};
      o.wben = 1'($urandom_range(0, 3) != 0); o.wbvec = 1'($urandom); o.rdi = 4'($urandom);
      o.vec = 1'($urandom);
      if (kind <= 1) o.ialu = 8'($urandom);
      else begin
        o.ialu = 8'($urandom) & 8'hC7;
        if (kind == 2) o.rd = 1; else o.wr = 1;
      end
      issue(o);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_idle(cnt);
    repeat (3) @(posedge clk); #1;
    chk("wb queue drained", wbq.size(), 0);
    chk("req queue drained", rqq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
